forward_hazard_unit: RTL
========================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter AW, default 5: register address width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..3: total stall cycles per load-use hazard.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 SHALL provide ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID-stage instruction valid.
- id_rs  in  AW  ID source A address.
- id_rt  in  AW  ID source B address.
- ex_we  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  AW  EX destination.
- mem_we  in  1  MEM instruction writes a register.
- mem_rd  in  AW  MEM destination.
- wb_we  in  1  WB instruction writes a register.
- wb_rd  in  AW  WB destination.
- flush  in  1  synchronous pipeline flush.
- fwd_a  out  2  registered operand-A select for the next EX cycle.
- fwd_b  out  2  registered operand-B select for the next EX cycle.
- stall  out  1  hold PC/ID, inject bubble into EX.
- stall_cnt  out  CNT_W  cycles with stall=1 since reset.

Function
REQ-005 Encoding SHALL be: 00 regfile, 10 EX result, 01 MEM result, 11 WB result.
REQ-006 Match for a stage SHALL require stage we=1, stage rd!=0, and rd equal to the source address; address 0 never forwards.
REQ-007 Priority SHALL be EX > MEM > WB; no match -> 00.
REQ-008 EX match where ex_is_load=1 SHALL NOT select 10; it raises a hazard instead.
REQ-009 Hazard SHALL be id_valid & ex_we & ex_is_load & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
REQ-010 FSM states SHALL be IDLE and HOLD, with a 2-bit down-counter rem.
REQ-011 IDLE: stall = hazard, combinational in the same cycle. On hazard with LOAD_LAT>1, go to HOLD with rem=LOAD_LAT-1. On hazard with LOAD_LAT=1, stay in IDLE.
REQ-012 HOLD: stall=1 regardless of inputs; rem decrements each cycle. Return to IDLE on the edge where rem=1. A hazard is therefore stalled for exactly LOAD_LAT cycles.
REQ-013 fwd_a/fwd_b update on every edge:
- flush=1 -> 00.
- else stall=1 -> 00 (bubble).
- else -> computed select.
REQ-014 flush=1 SHALL force state IDLE and rem=0 on the next edge. It SHALL combinationally mask stall to 0, and has priority over any simultaneous hazard.
REQ-015 stall_cnt SHALL increment on each edge where stall=1 and saturate at all-ones; flush does not clear it.
REQ-016 id_valid=0 SHALL suppress hazard detection only; forwarding selects are still computed.

Reset
REQ-017 rst=0 SHALL asynchronously force: fwd_a=00, fwd_b=00, state IDLE, rem=0, stall_cnt=0.
REQ-018 While rst=0, stall SHALL be 0.
REQ-019 Reset asserted mid-HOLD SHALL abort the stall immediately.
REQ-020 After rst returns to 1, the first edge SHALL behave as IDLE.

Verification
REQ-021 ALU chain: id_rs=3, ex_we=1, ex_rd=3, ex_is_load=0, mem_rd=3, mem_we=1 -> after edge fwd_a=10; stall=0.
REQ-022 Zero register: id_rt=0, ex_rd=0, ex_we=1 -> fwd_b=00. Separately: wb_rd=7, wb_we=1, id_rt=7, no other match -> fwd_b=11.
REQ-023 Load-use with LOAD_LAT=1: ex_is_load=1, ex_rd=5, id_rs=5, id_valid=1 -> stall=1 for one cycle, fwd_a=00 after edge, stall_cnt=1. Next cycle with load in MEM (mem_rd=5) -> fwd_a=01.
REQ-024 LOAD_LAT=3 same stimulus -> stall=1 for exactly 3 consecutive cycles, then 0; stall_cnt=3.
REQ-025 flush during HOLD (LOAD_LAT=3, second stall cycle) -> stall=0 in that cycle; IDLE next edge; fwd_a=fwd_b=00; stall_cnt=1.
REQ-026 CNT_W=2, continuous hazard for 6 cycles -> stall_cnt reaches 3 and holds. Then rst=0 mid-stall -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding select and load-use stall control
module forward_hazard_unit #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_rd,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_rd,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_rd,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b11;
    localparam logic [1:0] REM_INIT = 2'(LOAD_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic hazard, stall_raw;
    logic [1:0] sel_a, sel_b;

    assign ex_a  = ex_we  && (ex_rd  != '0) && (ex_rd  == id_rs);
    assign ex_b  = ex_we  && (ex_rd  != '0) && (ex_rd  == id_rt);
    assign mem_a = mem_we && (mem_rd != '0) && (mem_rd == id_rs);
    assign mem_b = mem_we && (mem_rd != '0) && (mem_rd == id_rt);
    assign wb_a  = wb_we  && (wb_rd  != '0) && (wb_rd  == id_rs);
    assign wb_b  = wb_we  && (wb_rd  != '0) && (wb_rd  == id_rt);

    assign hazard = id_valid && ex_is_load && (ex_a || ex_b);

    // A load still in EX is the youngest producer; older MEM/WB copies are stale,
    // so an EX load match yields the regfile select rather than falling through.
    always_comb begin
        sel_a = SEL_RF;
        if (ex_a)       sel_a = ex_is_load ? SEL_RF : SEL_EX;
        else if (mem_a) sel_a = SEL_MEM;
        else if (wb_a)  sel_a = SEL_WB;
    end

    always_comb begin
        sel_b = SEL_RF;
        if (ex_b)       sel_b = ex_is_load ? SEL_RF : SEL_EX;
        else if (mem_b) sel_b = SEL_MEM;
        else if (wb_b)  sel_b = SEL_WB;
    end

    assign stall_raw = (state_q == HOLD) || hazard;
    assign stall     = rst && !flush && stall_raw;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_d = HOLD;
                        rem_d   = REM_INIT;
                    end
                end
                HOLD: begin
                    if (rem_q <= 2'd1) begin
                        state_d = IDLE;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
        if (flush || stall) begin
            fwd_a_d = SEL_RF;
            fwd_b_d = SEL_RF;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= 2'd0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule
